// File: rtl/iqueue_sync_if.sv
// Fetch-to-decode handshake bundle for iqueue_sync.
// The slave modport is the queue side, and the master modport is the fetch/decode side.
interface iqueue_sync_if #(
  parameter int DEPTH = 16,
  parameter int GROUP = 8,
  parameter int DEQ   = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  i_drive;
  logic                  o_free;
  logic [32*GROUP-1:0]   i_instructions_256;
  logic [3:0]            i_cutCount_4;
  logic [31:0]           i_groupPc_32;
  logic                  i_flush;
  logic [CW-1:0]         o_vacancy_5;
  logic [CW-1:0]         o_count_5;
  logic [DEQ-1:0]        o_deqValid_2;
  logic [32*DEQ-1:0]     o_deqInst_64;
  logic [32*DEQ-1:0]     o_deqPc_64;
  logic [1:0]            i_deqTake_2;

  modport slave (
    input  i_drive, i_instructions_256, i_cutCount_4, i_groupPc_32, i_flush, i_deqTake_2,
    output o_free, o_vacancy_5, o_count_5, o_deqValid_2, o_deqInst_64, o_deqPc_64
  );

  modport master (
    output i_drive, i_instructions_256, i_cutCount_4, i_groupPc_32, i_flush, i_deqTake_2,
    input  o_free, o_vacancy_5, o_count_5, o_deqValid_2, o_deqInst_64, o_deqPc_64
  );
endinterface

// File: rtl/iqueue_sync.sv
// Instruction queue between branch-process and decode: accepts the cut fetch group and dequeues up to DEQ per cycle.
// Optional PC tagging is enabled by defining IQUEUE_PC_TAG_EN.
module iqueue_sync #(
  parameter int DEPTH = 16,
  parameter int GROUP = 8,
  parameter int DEQ   = 2
) (
  input  logic          clk,
  input  logic          rst,
  iqueue_sync_if.slave  q_if
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = (CW > 4) ? CW : 4;
  localparam logic [3:0] GROUP_N = 4'(GROUP);

  logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d, vacancy_q, vacancy_d;
  logic [31:0]       inst_mem_q [DEPTH];
  logic [3:0]        cut_n;
  logic              free;
  logic              accept;
  logic [CW-1:0]     avail;
  logic [CW-1:0]     take_req;
  logic [CW-1:0]     take_n;
  logic [DEQ-1:0]    deq_valid;
  logic [32*DEQ-1:0] deq_inst;
  logic [32*DEQ-1:0] deq_pc;

  always_comb begin
    cut_n = (q_if.i_cutCount_4 > GROUP_N) ? GROUP_N : q_if.i_cutCount_4;
  end

  // Reset blocks the handshake so nothing is accepted on the reset cycle.
  assign free   = !rst && !q_if.i_flush && (XW'(vacancy_q) >= XW'(cut_n));
  assign accept = q_if.i_drive && free;

  always_comb begin
    avail    = (count_q > CW'(DEQ)) ? CW'(DEQ) : count_q;
    take_req = CW'(q_if.i_deqTake_2);
    take_n   = (take_req > avail) ? avail : take_req;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (q_if.i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (accept) begin
        tail_d = tail_q + AW'(cut_n);
      end
      head_d  = head_q + AW'(take_n);
      count_d = count_q + (accept ? CW'(cut_n) : CW'(0)) - take_n;
    end
    vacancy_d = CW'(DEPTH) - count_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      vacancy_q <= CW'(DEPTH);
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      vacancy_q <= vacancy_d;
    end
  end

  // Storage is not reset; the read lanes are gated by valid instead.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < GROUP; k++) begin
        if (4'(k) < cut_n) begin
          inst_mem_q[tail_q + AW'(k)] <= q_if.i_instructions_256[32*k +: 32];
        end
      end
    end
  end

`ifdef IQUEUE_PC_TAG_EN
  logic [31:0] pc_mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < GROUP; k++) begin
        if (4'(k) < cut_n) begin
          pc_mem_q[tail_q + AW'(k)] <= q_if.i_groupPc_32 + (32'(k) << 2);
        end
      end
    end
  end

  always_comb begin
    deq_pc = '0;
    for (int j = 0; j < DEQ; j++) begin
      if (count_q > CW'(j)) begin
        deq_pc[32*j +: 32] = pc_mem_q[head_q + AW'(j)];
      end
    end
  end
`else
  logic unused_group_pc;
  assign unused_group_pc = ^q_if.i_groupPc_32;

  always_comb begin
    deq_pc = '0;
  end
`endif

  always_comb begin
    deq_valid = '0;
    deq_inst  = '0;
    for (int j = 0; j < DEQ; j++) begin
      deq_valid[j] = (count_q > CW'(j));
      if (deq_valid[j]) begin
        deq_inst[32*j +: 32] = inst_mem_q[head_q + AW'(j)];
      end
    end
  end

  assign q_if.o_free       = free;
  assign q_if.o_count_5    = count_q;
  assign q_if.o_vacancy_5  = vacancy_q;
  assign q_if.o_deqValid_2 = deq_valid;
  assign q_if.o_deqInst_64 = deq_inst;
  assign q_if.o_deqPc_64   = deq_pc;
endmodule

// File: tb/tb_iqueue_sync.sv
// Directed bench for iqueue_sync: a vector table for single-cycle behaviour, plus short sequences for reset and PC tags.
module tb_iqueue_sync;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  iqueue_sync_if #(.DEPTH(16), .GROUP(8), .DEQ(2)) iq ();

  iqueue_sync #(.DEPTH(16), .GROUP(8), .DEQ(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .q_if (iq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        drive;
    logic [3:0]  cut;
    logic [31:0] base;
    logic        flush;
    logic [1:0]  take;
    logic        exp_free;
    logic [4:0]  exp_count;
    logic [4:0]  exp_vac;
    logic [1:0]  exp_valid;
    logic [31:0] exp_i0;
    logic [31:0] exp_i1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic d, logic [3:0] c, logic [31:0] b, logic f, logic [1:0] t,
                              logic ef, logic [4:0] ec, logic [4:0] ev, logic [1:0] evl,
                              logic [31:0] e0, logic [31:0] e1);
    vec_t v;
    v.drive = d; v.cut = c; v.base = b; v.flush = f; v.take = t;
    v.exp_free = ef; v.exp_count = ec; v.exp_vac = ev; v.exp_valid = evl;
    v.exp_i0 = e0; v.exp_i1 = e1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic d, input logic [3:0] c, input logic [31:0] b,
                            input logic f, input logic [1:0] t, input logic [31:0] pc);
    iq.i_drive      = d;
    iq.i_cutCount_4 = c;
    iq.i_flush      = f;
    iq.i_deqTake_2  = t;
    iq.i_groupPc_32 = pc;
    for (int k = 0; k < 8; k++) iq.i_instructions_256[32*k +: 32] = b + 32'(k);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    set_inputs(1'b0, 4'd0, 32'h0, 1'b0, 2'd0, 32'h0);

    vecs.push_back(mk(1, 5, 32'h100, 0, 0, 1,  5, 11, 2'b11, 32'h100, 32'h101));
    vecs.push_back(mk(1, 8, 32'h200, 0, 0, 1, 13,  3, 2'b11, 32'h100, 32'h101));
    vecs.push_back(mk(1, 1, 32'h300, 0, 0, 1, 14,  2, 2'b11, 32'h100, 32'h101));
    vecs.push_back(mk(1, 3, 32'h400, 0, 0, 0, 14,  2, 2'b11, 32'h100, 32'h101));
    vecs.push_back(mk(1, 2, 32'h500, 0, 0, 1, 16,  0, 2'b11, 32'h100, 32'h101));
    vecs.push_back(mk(1, 0, 32'h580, 0, 0, 1, 16,  0, 2'b11, 32'h100, 32'h101));
    vecs.push_back(mk(1, 1, 32'h590, 0, 0, 0, 16,  0, 2'b11, 32'h100, 32'h101));
    // take 2 with a cut-1 group every cycle; tail and then head wrap
    vecs.push_back(mk(1, 1, 32'h600, 0, 2, 0, 14,  2, 2'b11, 32'h102, 32'h103));
    vecs.push_back(mk(1, 1, 32'h610, 0, 2, 1, 13,  3, 2'b11, 32'h104, 32'h200));
    vecs.push_back(mk(1, 1, 32'h620, 0, 2, 1, 12,  4, 2'b11, 32'h201, 32'h202));
    vecs.push_back(mk(1, 1, 32'h630, 0, 2, 1, 11,  5, 2'b11, 32'h203, 32'h204));
    vecs.push_back(mk(1, 1, 32'h640, 0, 2, 1, 10,  6, 2'b11, 32'h205, 32'h206));
    vecs.push_back(mk(1, 1, 32'h650, 0, 2, 1,  9,  7, 2'b11, 32'h207, 32'h300));
    vecs.push_back(mk(1, 1, 32'h660, 0, 2, 1,  8,  8, 2'b11, 32'h500, 32'h501));
    vecs.push_back(mk(1, 1, 32'h670, 0, 2, 1,  7,  9, 2'b11, 32'h610, 32'h620));
    vecs.push_back(mk(0, 0, 32'h0,   0, 2, 1,  5, 11, 2'b11, 32'h630, 32'h640));
    vecs.push_back(mk(0, 0, 32'h0,   0, 2, 1,  3, 13, 2'b11, 32'h650, 32'h660));
    vecs.push_back(mk(0, 0, 32'h0,   0, 2, 1,  1, 15, 2'b01, 32'h670, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   0, 2, 1,  0, 16, 2'b00, 32'h0,   32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   0, 2, 1,  0, 16, 2'b00, 32'h0,   32'h0));
    vecs.push_back(mk(1, 8, 32'h700, 0, 0, 1,  8,  8, 2'b11, 32'h700, 32'h701));
    vecs.push_back(mk(1, 1, 32'h800, 0, 0, 1,  9,  7, 2'b11, 32'h700, 32'h701));
    vecs.push_back(mk(1, 4, 32'h900, 1, 1, 0,  0, 16, 2'b00, 32'h0,   32'h0));
    vecs.push_back(mk(1, 2, 32'hA00, 0, 0, 1,  2, 14, 2'b11, 32'hA00, 32'hA01));
    vecs.push_back(mk(1, 0, 32'h0,   0, 1, 1,  1, 15, 2'b01, 32'hA01, 32'h0));
    vecs.push_back(mk(1, 15, 32'hB00, 0, 0, 1, 9,  7, 2'b11, 32'hA01, 32'hB00));
    vecs.push_back(mk(0, 0, 32'h0,   0, 3, 1,  7,  9, 2'b11, 32'hB01, 32'hB02));

    #12;
    chk("reset_count",   64'(iq.o_count_5),    64'd0);
    chk("reset_vacancy", 64'(iq.o_vacancy_5),  64'd16);
    chk("reset_valid",   64'(iq.o_deqValid_2), 64'd0);
    chk("reset_inst",    iq.o_deqInst_64,      64'd0);
    chk("reset_pc",      iq.o_deqPc_64,        64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      set_inputs(vecs[i].drive, vecs[i].cut, vecs[i].base, vecs[i].flush, vecs[i].take, 32'h0);
      #1;
      chk($sformatf("v%0d_free", i), 64'(iq.o_free), 64'(vecs[i].exp_free));
      @(posedge clk); #1;
      set_inputs(1'b0, 4'd0, 32'h0, 1'b0, 2'd0, 32'h0);
      chk($sformatf("v%0d_count", i), 64'(iq.o_count_5),    64'(vecs[i].exp_count));
      chk($sformatf("v%0d_vac", i),   64'(iq.o_vacancy_5),  64'(vecs[i].exp_vac));
      chk($sformatf("v%0d_valid", i), 64'(iq.o_deqValid_2), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid[0]) chk($sformatf("v%0d_inst0", i), 64'(iq.o_deqInst_64[31:0]),  64'(vecs[i].exp_i0));
      if (vecs[i].exp_valid[1]) chk($sformatf("v%0d_inst1", i), 64'(iq.o_deqInst_64[63:32]), 64'(vecs[i].exp_i1));
    end

    // reset in the middle of operation (7 entries held) while a group is offered
    set_inputs(1'b1, 4'd2, 32'hD00, 1'b0, 2'd0, 32'h0);
    rst = 1'b1;
    #1;
    chk("midrst_free",  64'(iq.o_free),       64'd0);
    chk("midrst_count", 64'(iq.o_count_5),    64'd0);
    chk("midrst_valid", 64'(iq.o_deqValid_2), 64'd0);
    @(posedge clk); #1;
    set_inputs(1'b0, 4'd0, 32'h0, 1'b0, 2'd0, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_count", 64'(iq.o_count_5),   64'd0);
    chk("postrst_vac",   64'(iq.o_vacancy_5), 64'd16);

    // PC tags: group at 0x8000_0010 with cut 3
    set_inputs(1'b1, 4'd3, 32'hC00, 1'b0, 2'd0, 32'h8000_0010);
    @(posedge clk); #1;
    set_inputs(1'b0, 4'd0, 32'h0, 1'b0, 2'd0, 32'h0);
    chk("pc_count", 64'(iq.o_count_5), 64'd3);
`ifdef IQUEUE_PC_TAG_EN
    chk("pc_lane0", 64'(iq.o_deqPc_64[31:0]),  64'h8000_0010);
    chk("pc_lane1", 64'(iq.o_deqPc_64[63:32]), 64'h8000_0014);
`else
    chk("pc_tied0", iq.o_deqPc_64, 64'd0);
`endif
    set_inputs(1'b0, 4'd0, 32'h0, 1'b0, 2'd2, 32'h0);
    @(posedge clk); #1;
    set_inputs(1'b0, 4'd0, 32'h0, 1'b0, 2'd0, 32'h0);
    chk("pc_inst_after", 64'(iq.o_deqInst_64[31:0]), 64'hC02);
    chk("pc_valid_after", 64'(iq.o_deqValid_2), 64'b01);
`ifdef IQUEUE_PC_TAG_EN
    chk("pc_lane0_after", 64'(iq.o_deqPc_64[31:0]), 64'h8000_0018);
`else
    chk("pc_tied0_after", iq.o_deqPc_64, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
